fx_block_accum: RTL



---
 rtl/fx_pkg.sv | 53 +++++
 rtl/fx_block_accum_if.sv | 26 ++
 rtl/fx_quant_sat.sv | 31 +++
 rtl/fx_block_accum.sv | 70 +++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared fixed-point helpers: rounding modes, round+shift and saturation.
package fx_pkg;

  // Working width for the helper functions; wide enough for any accumulator here.
  localparam int unsigned FX_W = 64;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } fx_rnd_e;

  typedef struct packed {
    logic signed [FX_W-1:0] value;
    logic                   sat;
  } fx_sat_t;

  // Drop 'shift' LSBs with an arithmetic shift; HALF_UP adds half an LSB first (ties toward +inf).
  function automatic logic signed [FX_W-1:0] fx_round_shift(
    input logic signed [FX_W-1:0] value,
    input int unsigned            shift,
    input fx_rnd_e                mode
  );
    logic signed [FX_W-1:0] bias;
    bias = '0;
    if ((shift != 0) && (mode == RND_HALF_UP)) begin
      bias = FX_W'(1) << (shift - 1);
    end
    return (value + bias) >>> shift;
  endfunction

  // Clamp a signed value into a signed 'width'-bit range and flag when clamping happened.
  function automatic fx_sat_t fx_sat(
    input logic signed [FX_W-1:0] value,
    input int unsigned            width
  );
    logic signed [FX_W-1:0] max_v;
    logic signed [FX_W-1:0] min_v;
    fx_sat_t                r;
    max_v   = (FX_W'(1) << (width - 1)) - FX_W'(1);
    min_v   = ~max_v;
    r.value = value;
    r.sat   = 1'b0;
    if (value > max_v) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if (value < min_v) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fx_block_accum_if.sv
// Sample-in / block-result-out bundle of the block accumulator.
interface fx_block_accum_if #(
  parameter int unsigned I_WIDTH   = 14,
  parameter int unsigned O_WIDTH   = 14,
  parameter int unsigned BLOCK_LEN = 8
);
  localparam int unsigned CNT_W = $clog2(BLOCK_LEN);

  logic                      i_clear;
  logic                      i_valid;
  logic signed [I_WIDTH-1:0] i_data;
  logic                      o_valid;
  logic signed [O_WIDTH-1:0] o_data;
  logic                      o_sat;
  logic [CNT_W-1:0]          o_cnt;

  modport master (
    output i_clear, i_valid, i_data,
    input  o_valid, o_data, o_sat, o_cnt
  );

  modport slave (
    input  i_clear, i_valid, i_data,
    output o_valid, o_data, o_sat, o_cnt
  );
endinterface

// File: rtl/fx_quant_sat.sv
// Combinational re-quantizer: round-half-up shift by SHIFT, then saturate to O_WIDTH.
module fx_quant_sat
  import fx_pkg::*;
#(
  parameter int unsigned IN_W    = 17,
  parameter int unsigned SHIFT   = 3,
  parameter int unsigned O_WIDTH = 14
) (
  input  logic signed [IN_W-1:0]    in_data,
  output logic signed [O_WIDTH-1:0] q_data_c,
  output logic                      q_sat_c
);

  logic signed [FX_W-1:0] in_wide;
  logic signed [FX_W-1:0] q_wide;
  fx_sat_t                sat_r;
  logic                   unused_hi;

  // Widen first so the rounding add can never wrap.
  always_comb begin
    in_wide = FX_W'(in_data);
    q_wide  = fx_round_shift(in_wide, SHIFT, RND_HALF_UP);
    sat_r   = fx_sat(q_wide, O_WIDTH);
  end

  assign q_data_c  = sat_r.value[O_WIDTH-1:0];
  assign q_sat_c   = sat_r.sat;
  // After saturation the upper bits are pure sign extension.
  assign unused_hi = ^sat_r.value[FX_W-1:O_WIDTH];

endmodule

// File: rtl/fx_block_accum.sv
// Integrate-and-dump: sums BLOCK_LEN valid samples and emits one re-quantized, saturated result.
module fx_block_accum
  import fx_pkg::*;
#(
  parameter int unsigned I_WIDTH   = 14,
  parameter int unsigned O_WIDTH   = 14,
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned SHIFT     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  fx_block_accum_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BLOCK_LEN);
  localparam int unsigned ACC_W = I_WIDTH + CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum_c;
  logic [CNT_W-1:0]          cnt;
  logic                      last_c;
  logic signed [O_WIDTH-1:0] q_data_c;
  logic                      q_sat_c;

  // Running sum including the current sample; sized so a full block cannot overflow.
  assign sum_c  = acc + ACC_W'(bus.i_data);
  assign last_c = (cnt == CNT_LAST);

  fx_quant_sat #(
    .IN_W    (ACC_W),
    .SHIFT   (SHIFT),
    .O_WIDTH (O_WIDTH)
  ) u_quant (
    .in_data  (sum_c),
    .q_data_c (q_data_c),
    .q_sat_c  (q_sat_c)
  );

  // Accumulate, dump on the final sample with no bubble, abort on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_sat   <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      if (bus.i_clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (bus.i_valid) begin
        if (last_c) begin
          acc         <= '0;
          cnt         <= '0;
          bus.o_valid <= 1'b1;
          bus.o_data  <= q_data_c;
          bus.o_sat   <= q_sat_c;
        end else begin
          acc <= sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.o_cnt = cnt;

endmodule
